wb_arb_mux: RTL

- N-master to 1-slave Wishbone B4 classic bus multiplexer, placed directly downstream of the arbiter block.
- Drives the arbiter's request/acknowledge inputs from the masters' CYC lines.
- Consumes the registered grant, latches the owning master, and routes that master's cycle to the single slave port.
- Returns ACK/ERR/read data to the owner only.

---
 rtl/wb_mux_pkg.sv | 24 ++
 rtl/wb_mux_watchdog.sv | 45 ++++
 rtl/wb_arb_mux.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/wb_mux_pkg.sv
// Shared types and helpers for the Wishbone arbiter-side bus multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_mux_pkg;

    // Ownership FSM: wait for a grant, route the owner, then one bubble cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // Widths for the default configuration (32-bit data, 2 masters).
    localparam int DEF_PORTS      = 2;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int SELW           = DEF_DATA_WIDTH / 8;
    localparam int IDXW           = $clog2(DEF_PORTS);

    // Low bit of slice idx in a flat bus of width-wide slices.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/wb_mux_watchdog.sv
// Slave no-response watchdog: counts stalled strobe cycles, pulses on expiry.
// Latency: expire_o is combinational in the TIMEOUT_CYCLES-th stalled cycle.
// Backpressure: none; counter clears on clr_i or on its own expiry.
module wb_mux_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and expiry: the cycle that would reach TIMEOUT_CYCLES fires.
    always_comb begin
        cnt_d    = cnt_q;
        expire_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            if (cnt_q == LAST) begin
                expire_o = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arb_mux.sv
// N-master to 1-slave Wishbone classic mux behind a blocking, acknowledge-mode arbiter.
// Latency: master CYC to slave CYC 2 cycles; handover 3 cycles from CYC drop to next slave CYC.
// Backpressure: slave ACK/ERR stall only the owner; optional watchdog (WB_MUX_TIMEOUT_EN) aborts hung slaves.
module wb_arb_mux
    import wb_mux_pkg::*;
#(
    parameter int PORTS          = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [PORTS*ADDR_WIDTH-1:0]        m_adr_i,
    input  logic [PORTS*DATA_WIDTH-1:0]        m_dat_i,
    input  logic [PORTS*(DATA_WIDTH/8)-1:0]    m_sel_i,
    input  logic [PORTS-1:0]                   m_we_i,
    input  logic [PORTS-1:0]                   m_stb_i,
    input  logic [PORTS-1:0]                   m_cyc_i,
    output logic [DATA_WIDTH-1:0]              m_dat_o,
    output logic [PORTS-1:0]                   m_ack_o,
    output logic [PORTS-1:0]                   m_err_o,
    output logic [ADDR_WIDTH-1:0]              s_adr_o,
    output logic [DATA_WIDTH-1:0]              s_dat_o,
    output logic [DATA_WIDTH/8-1:0]            s_sel_o,
    output logic                               s_we_o,
    output logic                               s_stb_o,
    output logic                               s_cyc_o,
    input  logic [DATA_WIDTH-1:0]              s_dat_i,
    input  logic                               s_ack_i,
    input  logic                               s_err_i,
    output logic [PORTS-1:0]                   arb_request_o,
    output logic [PORTS-1:0]                   arb_acknowledge_o,
    input  logic [PORTS-1:0]                   arb_grant_i,
    input  logic                               arb_grant_valid_i,
    input  logic [$clog2(PORTS)-1:0]           arb_grant_encoded_i,
    output logic                               timeout_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(PORTS);

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W-1:0]   sel_q;
    logic [IDX_W-1:0]   sel_d;
    logic               owned;
    logic               timed_out;
    logic               wd_expire;

    // One-hot grant is redundant with the encoded grant; kept on the port for integration.
    logic unused_inputs;
    assign unused_inputs = ^{arb_grant_i, (TIMEOUT_CYCLES != 0)};

    assign arb_request_o = m_cyc_i;
    assign m_dat_o       = s_dat_i;
    assign owned         = (state_q == OWNED);

    // Ownership FSM: latch the grant in IDLE, release with a one-cycle acknowledge.
    always_comb begin
        state_d           = state_q;
        sel_d             = sel_q;
        arb_acknowledge_o = '0;
        case (state_q)
            IDLE: begin
                if (arb_grant_valid_i) begin
                    sel_d = arb_grant_encoded_i;
                    if (m_cyc_i[arb_grant_encoded_i]) begin
                        state_d = OWNED;
                    end else begin
                        // Grant for a master that already gave up: hand it straight back.
                        arb_acknowledge_o[arb_grant_encoded_i] = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            OWNED: begin
                if (!m_cyc_i[sel_q]) begin
                    arb_acknowledge_o[sel_q] = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Route the owner to the slave and the slave response back to the owner only.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        if (owned) begin
            s_cyc_o = m_cyc_i[sel_q] & ~timed_out;
            s_stb_o = m_stb_i[sel_q] & ~timed_out;
            s_adr_o = m_adr_i[slice_lo(int'(sel_q), ADDR_WIDTH) +: ADDR_WIDTH];
            s_dat_o = m_dat_i[slice_lo(int'(sel_q), DATA_WIDTH) +: DATA_WIDTH];
            s_sel_o = m_sel_i[slice_lo(int'(sel_q), SEL_W) +: SEL_W];
            s_we_o  = m_we_i[sel_q];
            m_ack_o[sel_q] = s_ack_i;
            m_err_o[sel_q] = s_err_i | wd_expire;
        end
    end

`ifdef WB_MUX_TIMEOUT_EN
    logic to_q;
    logic to_d;

    wb_mux_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_en_i (owned & s_stb_o & ~s_ack_i & ~s_err_i),
        .clr_i    (~owned | s_ack_i | s_err_i),
        .expire_o (wd_expire)
    );

    // Timed-out flag holds the slave side quiet until the owner leaves.
    always_comb begin
        to_d = to_q;
        if (!owned) begin
            to_d = 1'b0;
        end else if (wd_expire) begin
            to_d = 1'b1;
        end
    end

    // Timed-out flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q <= 1'b0;
        end else begin
            to_q <= to_d;
        end
    end

    assign timed_out = to_q;
    assign timeout_o = wd_expire;
`else
    assign timed_out = 1'b0;
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule
